// File: rtl/ha_array_pkg.sv
// Shared types and constants for the half-adder array accumulator.
package ha_array_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned TW   = 9;
    localparam int unsigned BW   = 7;
    localparam int unsigned PW   = 16;
    localparam int unsigned AW   = 17;              // accumulator width, one guard bit above PW
    localparam int unsigned IDXW = $clog2(ROWS);

    localparam logic [PW-1:0] SAT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_e;

    // One array row: t bits start at weight 2^(2k), b bits at 2^(2k+2).
    typedef struct packed {
        logic [TW-1:0] t;
        logic [BW-1:0] b;
    } ha_row_t;

    typedef ha_row_t [ROWS-1:0] ha_bundle_t;

    // Clamp the accumulator to the product width.
    function automatic logic [PW-1:0] saturate(input logic [AW-1:0] acc);
        return acc[AW-1] ? SAT_MAX : acc[PW-1:0];
    endfunction

endpackage

// File: rtl/ha_row_weight.sv
// Combinational row weighting: rv = (t + (b << 2)) << 2*idx, at accumulator width.
module ha_row_weight
    import ha_array_pkg::*;
(
    input  logic [TW-1:0]   t_i,
    input  logic [BW-1:0]   b_i,
    input  logic [IDXW-1:0] idx_i,
    output logic [AW-1:0]   rv_o
);

    logic [AW-1:0] base;

    // Row-local sum, then shift by the row's weight of 4^idx.
    always_comb begin
        base = AW'(t_i) + (AW'(b_i) << 2);
        rv_o = base << {idx_i, 1'b0};
    end

endmodule

// File: rtl/ha_array_accumulator.sv
// Sequential reducer for the four-row half-adder array.
// Captures one bundle, adds one row per clock into a 17-bit accumulator and
// presents the saturated 16-bit product under a valid/ready handshake.
// Build option HA_ACC_DUAL_ROW_EN: add two rows per clock (three-input adder).
module ha_array_accumulator
    import ha_array_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [TW-1:0] ha_array_0_t,
    input  logic [BW-1:0] ha_array_0_b,
    input  logic [TW-1:0] ha_array_1_t,
    input  logic [BW-1:0] ha_array_1_b,
    input  logic [TW-1:0] ha_array_2_t,
    input  logic [BW-1:0] ha_array_2_b,
    input  logic [TW-1:0] ha_array_3_t,
    input  logic [BW-1:0] ha_array_3_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] product,
    output logic          busy
);

`ifdef HA_ACC_DUAL_ROW_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif

    state_e          state_q;
    ha_bundle_t      bundle_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_d;
    logic [IDXW-1:0] idx_q;
    logic [PW-1:0]   product_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            busy_q;

    logic            accept;
    logic            last_step;
    logic [AW-1:0]   rv0;

    assign accept    = (state_q == IDLE) && in_valid;
    assign last_step = (idx_q == IDXW'(ROWS - STEP));

    ha_row_weight u_row_weight0 (
        .t_i   (bundle_q[idx_q].t),
        .b_i   (bundle_q[idx_q].b),
        .idx_i (idx_q),
        .rv_o  (rv0)
    );

`ifdef HA_ACC_DUAL_ROW_EN
    logic [IDXW-1:0] idx1;
    logic [AW-1:0]   rv1;

    assign idx1 = idx_q + IDXW'(1);

    ha_row_weight u_row_weight1 (
        .t_i   (bundle_q[idx1].t),
        .b_i   (bundle_q[idx1].b),
        .idx_i (idx1),
        .rv_o  (rv1)
    );

    // Next accumulator value: current sum plus the row pair at idx.
    always_comb begin
        // NOTE: assign a default first so no path leaves acc_d unassigned (no latch).
        acc_d = acc_q;
        acc_d = acc_q + rv0 + rv1;
    end
`else
    // Next accumulator value: current sum plus the row at idx.
    always_comb begin
        // NOTE: assign a default first so no path leaves acc_d unassigned (no latch).
        acc_d = acc_q;
        acc_d = acc_q + rv0;
    end
`endif

    // Bundle capture on the accept edge; held unchanged until the next accept.
    // NOTE: no reset here -- the bundle is only read after a fresh capture, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            bundle_q[0] <= '{t: ha_array_0_t, b: ha_array_0_b};
            bundle_q[1] <= '{t: ha_array_1_t, b: ha_array_1_b};
            bundle_q[2] <= '{t: ha_array_2_t, b: ha_array_2_b};
            bundle_q[3] <= '{t: ha_array_3_t, b: ha_array_3_b};
        end
    end

    // Control FSM with registered handshake outputs, product and busy.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ACC;
                    end
                end
                ACC: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + IDXW'(STEP);
                    if (last_step) begin
                        product_q   <= saturate(acc_d);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Self-checking bench for ha_array_accumulator against an arithmetic row-sum model.
module tb_ha_array_accumulator;

`ifdef HA_ACC_DUAL_ROW_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif
    localparam int PERIOD = LAT + 2;
    localparam int BOUND  = 40;

    typedef logic [3:0][8:0] tvec_t;
    typedef logic [3:0][6:0] bvec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  t_in [4];
    logic [6:0]  b_in [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ha_array_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_t (t_in[0]),
        .ha_array_0_b (b_in[0]),
        .ha_array_1_t (t_in[1]),
        .ha_array_1_b (b_in[1]),
        .ha_array_2_t (t_in[2]),
        .ha_array_2_b (b_in[2]),
        .ha_array_3_t (t_in[3]),
        .ha_array_3_b (b_in[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    // Reference: sum over rows of (t + 4*b) * 4^k, clamped at 16 bits.
    function automatic logic [15:0] model(input tvec_t t, input bvec_t b);
        int s = 0;
        for (int k = 0; k < 4; k++) s += (int'(t[k]) + 4 * int'(b[k])) * (4 ** k);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input tvec_t t, input bvec_t b);
        for (int k = 0; k < 4; k++) begin
            t_in[k] = t[k];
            b_in[k] = b[k];
        end
    endtask

    task automatic rand_bundle(output tvec_t t, output bvec_t b);
        for (int k = 0; k < 4; k++) begin
            t[k] = 9'($urandom_range(0, 511));
            b[k] = 7'($urandom_range(0, 127));
        end
    endtask

    // Present a bundle, accept it, and wait for out_valid; returns product and latency.
    task automatic do_txn(input tvec_t t, input bvec_t b, output logic [15:0] prod, output int lat);
        int n = 0;
        while (in_ready !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_wait: in_ready=%b required 1 within %0d cycles", in_ready, BOUND);
        end
        set_inputs(t, b);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < BOUND) begin
            tick();
            lat++;
        end
        prod = product;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_inputs('0, '0);
        #23;
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_state: rdy/vld/busy=%b prod=%h required 100 prod=0000",
                     {in_ready, out_valid, busy}, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        tvec_t t[6];
        bvec_t b[6];
        logic [15:0] exp_p [6];
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 6; i++) begin
            t[i] = '0;
            b[i] = '0;
        end
        t[1][0] = 9'h001;  exp_p[1] = 16'd1;
        b[2][1] = 7'h01;   exp_p[2] = 16'd16;
        t[3][3] = 9'h001;  exp_p[3] = 16'd64;
        b[4][3] = 7'h40;   exp_p[4] = 16'd16384;
        for (int k = 0; k < 4; k++) begin
            t[5][k] = 9'h1FF;
            b[5][k] = 7'h7F;
        end
        exp_p[0] = 16'h0000;
        exp_p[5] = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            out_ready = (i == 0);
            do_txn(t[i], b[i], p, lat);
            n_cmp++;
            if (p !== exp_p[i] || p !== model(t[i], b[i])) begin
                n_err++;
                $display("FAIL directed_%0d: product=%h required %h", i, p, exp_p[i]);
            end
            n_cmp++;
            if (lat !== LAT) begin
                n_err++;
                $display("FAIL latency_%0d: latency=%0d required %0d", i, lat, LAT);
            end
            drain();
        end
    endtask

    task automatic test_random();
        tvec_t t;
        bvec_t b;
        logic [15:0] p;
        int lat;
        for (int i = 0; i < 24; i++) begin
            rand_bundle(t, b);
            if (i % 4 == 1) for (int k = 0; k < 4; k++) t[k] = t[k] >> 6;
            if (i % 4 == 2) t[3] = '0;
            if (i % 4 == 2) b[3] = '0;
            out_ready = i[0];
            do_txn(t, b, p, lat);
            n_cmp++;
            if (p !== model(t, b) || lat !== LAT) begin
                n_err++;
                $display("FAIL random_%0d: product=%h lat=%0d required %h lat=%0d",
                         i, p, lat, model(t, b), LAT);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        tvec_t t;
        bvec_t b;
        logic [15:0] p;
        int lat;
        rand_bundle(t, b);
        out_ready = 1'b0;
        do_txn(t, b, p, lat);
        n_cmp++;
        if (p !== model(t, b)) begin
            n_err++;
            $display("FAIL bp_product: product=%h required %h", p, model(t, b));
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || product !== p || in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold_%0d: vld=%b prod=%h rdy=%b busy=%b required 1 %h 0 1",
                         c, out_valid, product, in_ready, busy, p);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: vld/rdy/busy=%b required 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_isolation();
        tvec_t t, tj;
        bvec_t b, bj;
        int n = 0;
        bit bad = 0;
        rand_bundle(t, b);
        set_inputs(t, b);
        in_valid = 1'b1;
        tick();
        while (out_valid !== 1'b1 && n < BOUND) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1;
            rand_bundle(tj, bj);
            set_inputs(tj, bj);
            in_valid = ~in_valid;
            tick();
            n++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL iso_acc_flags: in_ready/busy wrong during ACC, required 0/1");
        end
        n_cmp++;
        if (product !== model(t, b) || n !== LAT) begin
            n_err++;
            $display("FAIL iso_product: product=%h lat=%0d required %h lat=%0d",
                     product, n, model(t, b), LAT);
        end
        drain();
    endtask

    task automatic test_reset_mid_acc();
        tvec_t t;
        bvec_t b;
        logic [15:0] p;
        int lat;
        bit seen = 0;
        rand_bundle(t, b);
        t[0] = 9'h1FF;
        set_inputs(t, b);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_acc: vld=%b prod=%h rdy=%b busy=%b required 0 0000 1 0",
                     out_valid, product, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL rst_no_output: out_valid=1 after reset, required 0");
        end
        rand_bundle(t, b);
        do_txn(t, b, p, lat);
        n_cmp++;
        if (p !== model(t, b) || lat !== LAT) begin
            n_err++;
            $display("FAIL rst_fresh: product=%h lat=%0d required %h lat=%0d", p, lat, model(t, b), LAT);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        tvec_t ta, tb;
        bvec_t ba, bb;
        int e = 0, first = -1, second = -1, n = 0;
        logic rdy;
        logic [15:0] pa = 16'hxxxx;
        rand_bundle(ta, ba);
        rand_bundle(tb, bb);
        out_ready = 1'b1;
        set_inputs(ta, ba);
        in_valid = 1'b1;
        while (second < 0 && e < BOUND) begin
            rdy = in_ready;
            tick();
            e++;
            if (rdy) begin
                if (first < 0) begin
                    first = e;
                    set_inputs(tb, bb);
                end else begin
                    second = e;
                end
            end
            if (out_valid === 1'b1 && second < 0) pa = product;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (second - first !== PERIOD) begin
            n_err++;
            $display("FAIL b2b_period: period=%0d required %0d", second - first, PERIOD);
        end
        n_cmp++;
        if (pa !== model(ta, ba)) begin
            n_err++;
            $display("FAIL b2b_first: product=%h required %h", pa, model(ta, ba));
        end
        while (out_valid !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        n_cmp++;
        if (product !== model(tb, bb) || n !== LAT) begin
            n_err++;
            $display("FAIL b2b_second: product=%h lat=%0d required %h lat=%0d",
                     product, n, model(tb, bb), LAT);
        end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_isolation();
        test_reset_mid_acc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
